// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that lets N_REQ sprite fetchers share one synchronous ROM.
// Responses come back as one-hot strobes in grant order, ROM_LAT+1 cycles after acceptance.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [15:0]             busy_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]       busy_cnt_q, busy_cnt_d;
    logic [ROM_LAT:0]  tag_v_q;
    logic [IDX_W-1:0]  tag_idx_q [ROM_LAT:0];

    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic              accept;
    logic              rsp_fire;
    logic              waiting;
    logic [IDX_W:0]    cand;
    logic [IDX_W-1:0]  cand_idx;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            cand_idx = cand[IDX_W-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        accept    = grant_found && !rst;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign waiting  = |(req_valid & ~req_ready);
    assign rsp_fire = tag_v_q[ROM_LAT];

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        rsp_data_d = rsp_data_q;
        busy_cnt_d = busy_cnt_q;
        if (accept) begin
            ptr_d      = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            rom_addr_d = req_addr[grant_idx*ADDR_W +: ADDR_W];
        end
        if (rsp_fire) begin
            rsp_data_d = rom_q;
        end
        if (waiting && busy_cnt_q != 16'hFFFF) begin
            busy_cnt_d = busy_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            rsp_data_q <= '0;
            busy_cnt_q <= '0;
            tag_v_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            rsp_data_q <= rsp_data_d;
            busy_cnt_q <= busy_cnt_d;
            tag_v_q    <= {tag_v_q[ROM_LAT-1:0], accept};
        end
    end

    // Tag indices need no reset: they are only looked at alongside a set valid bit.
    always_ff @(posedge clk) begin
        tag_idx_q[0] <= grant_idx;
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_idx_q[k] <= tag_idx_q[k-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_fire) begin
            rsp_valid[tag_idx_q[ROM_LAT]] = 1'b1;
        end
    end

    // Data is passed straight from the ROM in the response cycle and held afterwards.
    assign rsp_data = rsp_fire ? rom_q : rsp_data_q;
    assign rom_addr = rom_addr_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one instance with ROM_LAT=1 and one with
// ROM_LAT=3 share the request inputs; each has its own ROM model where mem[a] = a.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]    req_ready1, rsp_valid1;
  logic [AW-1:0]   rom_addr1;
  logic [DW-1:0]   rom_q1, rsp_data1;
  logic [15:0]     busy_cnt1;

  logic [N-1:0]    req_ready3, rsp_valid3;
  logic [AW-1:0]   rom_addr3;
  logic [DW-1:0]   rom_q3, rsp_data3;
  logic [15:0]     busy_cnt3;

  logic [AW-1:0]   r1_a;
  logic [AW-1:0]   r3_a, r3_b, r3_c;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_idx_q[$];

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready1), .rom_addr(rom_addr1), .rom_q(rom_q1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy_cnt(busy_cnt1)
  );

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready3), .rom_addr(rom_addr3), .rom_q(rom_q3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy_cnt(busy_cnt3)
  );

  // ROM models: address registered ROM_LAT times, contents equal the address.
  always @(posedge clk) begin
    r1_a <= rom_addr1;
    r3_a <= rom_addr3;
    r3_b <= r3_a;
    r3_c <= r3_b;
  end
  assign rom_q1 = {2'b00, r1_a};
  assign rom_q3 = {2'b00, r3_c};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_addr(i, AW'(14'h0040 + i));
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (req_ready1 !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected %b", req_ready1, 4'b0000);
    end
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_busy: got %h expected %h", busy_cnt1, 16'd0);
    end
    checks++;
    if (rom_addr1 !== 14'd0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %h expected %h", rom_addr1, 14'd0);
    end
    checks++;
    if (rsp_data1 !== 16'd0 || rsp_valid1 !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rsp: got valid %b data %h expected 0000 0000", rsp_valid1, rsp_data1);
    end
    checks++;
    if (req_ready1 !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ready: got %b expected %b", req_ready1, 4'b0000);
    end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    set_addr(0, 14'h0123);
    @(negedge clk);
    checks++;
    if (req_ready1 !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b expected %b", req_ready1, 4'b0001);
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rom_addr1 !== 14'h0123 || rsp_valid1 !== 4'b0000) begin
      errors++;
      $display("FAIL single_rom_addr: got %h/%b expected 0123/0000", rom_addr1, rsp_valid1);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid1 !== 4'b0001 || rsp_data1 !== 16'h0123) begin
      errors++;
      $display("FAIL single_rsp: got %b/%h expected 0001/0123", rsp_valid1, rsp_data1);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid1 !== 4'b0000 || rsp_data1 !== 16'h0123 || busy_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL single_hold: got %b/%h/%h expected 0000/0123/0000", rsp_valid1, rsp_data1, busy_cnt1);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [N-1:0] e;
    logic [DW-1:0] ed;
    int ei;
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, AW'(14'h0200 + i));
    exp_q.delete();
    exp_idx_q.delete();
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (k < 8) begin
        e = 4'b0001 << exp_g[k];
        checks++;
        if (req_ready1 !== e) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready1, e);
        end
        exp_q.push_back(DW'(16'h0200 + exp_g[k]));
        exp_idx_q.push_back(exp_g[k]);
      end
      if (k >= 2) begin
        ed = exp_q.pop_front();
        ei = exp_idx_q.pop_front();
        e = 4'b0001 << ei;
        checks++;
        if (rsp_valid1 !== e || rsp_data1 !== ed) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid1, rsp_data1, e, ed);
        end
      end
      if (k == 8) begin
        checks++;
        if (busy_cnt1 !== 16'd8) begin
          errors++;
          $display("FAIL rr_busy: got %0d expected 8", busy_cnt1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_partial();
    logic [N-1:0] exp_r[6] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    logic [N-1:0] exp_s[6] = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [DW-1:0] exp_d[6] = '{16'h0, 16'h0, 16'h0501, 16'h0503, 16'h0501, 16'h0503};
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, AW'(14'h0500 + i));
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      checks++;
      if (req_ready1 !== exp_r[k]) begin
        errors++;
        $display("FAIL partial_grant[%0d]: got %b expected %b", k, req_ready1, exp_r[k]);
      end
      checks++;
      if (rsp_valid1 !== exp_s[k] || (exp_s[k] != 0 && rsp_data1 !== exp_d[k])) begin
        errors++;
        $display("FAIL partial_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid1, rsp_data1, exp_s[k], exp_d[k]);
      end
      if (k == 4) begin
        checks++;
        if (busy_cnt1 !== 16'd4) begin
          errors++;
          $display("FAIL partial_busy: got %0d expected 4", busy_cnt1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_drop_and_stream();
    logic [N-1:0] vin[8]   = '{4'b0011, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b0000, 4'b0000};
    logic [N-1:0] exp_r[8] = '{4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [N-1:0] exp_s[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    logic [DW-1:0] exp_d[8] = '{16'h0, 16'h0, 16'h0300, 16'h0, 16'h0302, 16'h0302, 16'h0302, 16'h0303};
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, AW'(14'h0300 + i));
    for (int k = 0; k < 8; k++) begin
      req_valid = vin[k];
      @(negedge clk);
      checks++;
      if (req_ready1 !== exp_r[k]) begin
        errors++;
        $display("FAIL drop_grant[%0d]: got %b expected %b", k, req_ready1, exp_r[k]);
      end
      checks++;
      if (rsp_valid1 !== exp_s[k] || (exp_s[k] != 0 && rsp_data1 !== exp_d[k])) begin
        errors++;
        $display("FAIL drop_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid1, rsp_data1, exp_s[k], exp_d[k]);
      end
      if (k == 7) begin
        checks++;
        if (busy_cnt1 !== 16'd2) begin
          errors++;
          $display("FAIL drop_busy: got %0d expected 2", busy_cnt1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_addr(2, 14'h0ABC);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready1 !== 4'b0100) begin
      errors++;
      $display("FAIL inflight_grant: got %b expected %b", req_ready1, 4'b0100);
    end
    next_cycle();
    req_valid = '0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid1 !== 4'b0000 || rsp_valid3 !== 4'b0000) begin
        errors++;
        $display("FAIL inflight_rsp[%0d]: got %b/%b expected 0000/0000", k, rsp_valid1, rsp_valid3);
      end
      next_cycle();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready1 !== 4'b0001 || busy_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL inflight_after: got %b/%h expected 0001/0000", req_ready1, busy_cnt1);
    end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      req_valid = 4'b0011;
      if (i == 65534 || i == 65535 || i == 65539) begin
        @(negedge clk);
        checks++;
        if (busy_cnt1 !== ((i == 65534) ? 16'hFFFE : 16'hFFFF)) begin
          errors++;
          $display("FAIL sat_busy[%0d]: got %h expected %h", i, busy_cnt1,
                   (i == 65534) ? 16'hFFFE : 16'hFFFF);
        end
      end
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy_cnt1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final: got %h expected FFFF", busy_cnt1);
    end
    next_cycle();
  endtask

  task automatic test_lat3();
    logic [N-1:0] exp_r[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [N-1:0] exp_s[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    logic [DW-1:0] exp_d[8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0021, 16'h0032, 16'h0};
    do_reset();
    set_addr(0, 14'h0010);
    set_addr(1, 14'h0021);
    set_addr(2, 14'h0032);
    set_addr(3, 14'h0043);
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 3) ? 4'b0111 : 4'b0000;
      @(negedge clk);
      checks++;
      if (req_ready3 !== exp_r[k]) begin
        errors++;
        $display("FAIL lat3_grant[%0d]: got %b expected %b", k, req_ready3, exp_r[k]);
      end
      checks++;
      if (rsp_valid3 !== exp_s[k] || (exp_s[k] != 0 && rsp_data3 !== exp_d[k])) begin
        errors++;
        $display("FAIL lat3_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid3, rsp_data3, exp_s[k], exp_d[k]);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_partial();
    test_drop_and_stream();
    test_reset_inflight();
    test_lat3();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
